// File: rtl/datapath_ctrl.sv
// datapath_ctrl: micro-instruction sequencer for the 8-entry register-file /
// ALU / shifter datapath. It accepts 12-bit instructions over valid/ready and
// drives per-cycle datapath controls. A one-cycle done pulse marks the end of
// each instruction.
//
// All outputs come straight from flops. The controls for the next state are
// decoded before the edge and registered together with the state, so no
// input reaches an output combinationally.
//
// Optional feature: define DATAPATH_CTRL_PERF_CNT_EN to build a wrapping
// retired-instruction counter on instr_count. When the macro is undefined,
// instr_count is tied to 0 and no counter flops are built.
module datapath_ctrl #(
  parameter int INSTR_WIDTH = 12,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic [INSTR_WIDTH-1:0] instr,
  input  logic                   instr_valid,
  output logic                   instr_ready,
  output logic                   busy,
  output logic                   done,
  output logic                   IE,
  output logic                   WE,
  output logic [2:0]             WA,
  output logic [2:0]             RAA,
  output logic                   REA,
  output logic [2:0]             RAB,
  output logic                   REB,
  output logic [1:0]             alu_op,
  output logic                   shift_en,
  output logic                   OE,
  output logic [CNT_WIDTH-1:0]   instr_count
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    NOP_S  = 3'd1,
    LOAD_S = 3'd2,
    RD_S   = 3'd3,
    WR_S   = 3'd4,
    OUT_S  = 3'd5
  } state_t;

  typedef struct packed {
    logic       instr_ready;
    logic       busy;
    logic       done;
    logic       ie;
    logic       we;
    logic [2:0] wa;
    logic [2:0] raa;
    logic       rea;
    logic [2:0] rab;
    logic       reb;
    logic [1:0] alu_op;
    logic       shift_en;
    logic       oe;
  } ctrl_t;

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [INSTR_WIDTH-1:0] instr_r;
  logic [INSTR_WIDTH-1:0] instr_nxt_s;
  ctrl_t                  ctrl_r;

  // Control decode for one state / captured instruction pair.
  // Every field not named for a state is left at 0, including the addresses.
  function automatic ctrl_t decode(input state_t st, input logic [INSTR_WIDTH-1:0] ir);
    ctrl_t c;
    c = '0;
    case (st)
      IDLE: begin
        c.instr_ready = 1'b1;
      end
      NOP_S: begin
        c.busy = 1'b1;
        c.done = 1'b1;
      end
      LOAD_S: begin
        c.busy = 1'b1;
        c.ie   = 1'b1;
        c.we   = 1'b1;
        c.wa   = ir[8:6];
        c.done = 1'b1;
      end
      RD_S, WR_S: begin
        // The read side is identical in both cycles. WR_S adds the write.
        c.busy = 1'b1;
        c.rea  = 1'b1;
        c.reb  = 1'b1;
        c.raa  = ir[5:3];
        c.rab  = ir[2:0];
        case (ir[11:9])
          3'b011:  c.alu_op = 2'b01;
          3'b100:  c.alu_op = 2'b10;
          3'b101:  c.alu_op = 2'b11;
          3'b110:  c.shift_en = 1'b1;
          default: c.alu_op = 2'b00;
        endcase
        case (st)
          WR_S: begin
            c.we   = 1'b1;
            c.wa   = ir[8:6];
            c.done = 1'b1;
          end
          default: c.we = 1'b0;
        endcase
      end
      OUT_S: begin
        c.busy = 1'b1;
        c.rea  = 1'b1;
        c.raa  = ir[5:3];
        c.oe   = 1'b1;
        c.done = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Next-state and instruction-capture selection.
  // A new instruction is taken only in IDLE, so valid is ignored while busy.
  always_comb begin
    state_nxt_s = state_r;
    instr_nxt_s = instr_r;
    case (state_r)
      IDLE: begin
        if (instr_valid) begin
          instr_nxt_s = instr;
          case (instr[11:9])
            3'b000:  state_nxt_s = NOP_S;
            3'b001:  state_nxt_s = LOAD_S;
            3'b111:  state_nxt_s = OUT_S;
            default: state_nxt_s = RD_S;
          endcase
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RD_S:    state_nxt_s = WR_S;
      NOP_S,
      LOAD_S,
      WR_S,
      OUT_S:   state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, captured instruction and registered control outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r <= IDLE;
      instr_r <= {INSTR_WIDTH{1'b0}};
      ctrl_r  <= decode(IDLE, {INSTR_WIDTH{1'b0}});
    end else begin
      state_r <= state_nxt_s;
      instr_r <= instr_nxt_s;
      ctrl_r  <= decode(state_nxt_s, instr_nxt_s);
    end
  end

  assign instr_ready = ctrl_r.instr_ready;
  assign busy        = ctrl_r.busy;
  assign done        = ctrl_r.done;
  assign IE          = ctrl_r.ie;
  assign WE          = ctrl_r.we;
  assign WA          = ctrl_r.wa;
  assign RAA         = ctrl_r.raa;
  assign REA         = ctrl_r.rea;
  assign RAB         = ctrl_r.rab;
  assign REB         = ctrl_r.reb;
  assign alu_op      = ctrl_r.alu_op;
  assign shift_en    = ctrl_r.shift_en;
  assign OE          = ctrl_r.oe;

`ifdef DATAPATH_CTRL_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] cnt_r;

  // Retired-instruction counter. It counts every cycle that shows done and
  // wraps naturally.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_r <= {CNT_WIDTH{1'b0}};
    end else if (ctrl_r.done) begin
      cnt_r <= cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign instr_count = cnt_r;
`else
  assign instr_count = {CNT_WIDTH{1'b0}};
`endif

endmodule

// File: doc/datapath_ctrl.md
Name: datapath_ctrl

Overview:
- FSM sequencer for the 8-entry register-file / ALU / shifter datapath.
- Accepts 12-bit micro-instructions over a valid/ready handshake.
- Decodes each one into per-cycle datapath controls: IE, WE, WA, RAA/REA, RAB/REB, alu_op, shift_en, OE.
- Signals completion with a one-cycle done pulse. Sits between a host/test sequencer and the datapath top.

Parameters:
- INSTR_WIDTH, 12, instruction word width; fixed layout below, other values unsupported.
- CNT_WIDTH, 16, retired-instruction counter width (optional feature only).

Ports:
- CLK  input  1  rising-edge clock
- RST_N  input  1  asynchronous active-low reset
- instr  input  INSTR_WIDTH  {op[11:9], dst[8:6], srca[5:3], srcb[2:0]}
- instr_valid  input  1  instr is valid
- instr_ready  output  1  controller can accept an instruction
- busy  output  1  instruction in flight
- done  output  1  one-cycle pulse in the final cycle of each instruction
- IE  output  1  write-data mux select: 1 = Inport, 0 = shifter
- WE  output  1  register-file write enable
- WA  output  3  write address
- RAA  output  3  port-A read address
- REA  output  1  port-A read enable
- RAB  output  3  port-B read address
- REB  output  1  port-B read enable
- alu_op  output  2  ALU operation
- shift_en  output  1  shifter enable
- OE  output  1  output-port enable
- instr_count  output  CNT_WIDTH  retired count (only with the optional feature)

Behaviour:
- Reset (RST_N low, asynchronous): state = IDLE, captured instruction = 0.
  - All datapath controls, done, busy = 0; instr_ready = 1.
- Outputs are decoded from the state register and the captured instruction register only; no combinational path from instr or instr_valid to any output.
- Handshake:
  - instr_ready = (state == IDLE).
  - Transfer occurs on a rising edge with instr_valid && instr_ready; instr is captured and the next state is chosen from op.
  - instr_valid while not ready is ignored; the source must hold it.
- Opcodes:
  - 000 NOP
  - 001 LOAD: R[dst] <= Inport
  - 010 ADD: alu_op = 00
  - 011 SUB: alu_op = 01
  - 100 AND: alu_op = 10
  - 101 OR: alu_op = 11
  - 110 ADDSH: alu_op = 00, shift_en = 1
  - 111 OUT: drive R[srca] to Outport
- States and transitions:
  - IDLE -> NOP_S | LOAD_S | RD_S | OUT_S on accept.
  - NOP_S: done = 1 -> IDLE.
  - LOAD_S: IE = 1, WE = 1, WA = dst, done = 1 -> IDLE.
  - RD_S: REA = REB = 1, RAA = srca, RAB = srcb, alu_op/shift_en per op -> WR_S.
  - WR_S: same read controls held, plus WE = 1, WA = dst, IE = 0, done = 1 -> IDLE.
  - OUT_S: REA = 1, RAA = srca, OE = 1, done = 1 -> IDLE.
- Latency, counted from the accept edge: NOP/LOAD/OUT = 1 cycle, ALU ops = 2 cycles.
  - Every instruction is followed by one IDLE cycle, so peak throughput is one instruction per 2 or 3 cycles.
- busy = 1 in every non-IDLE state.
- All controls not listed for a state are 0, including WA/RAA/RAB = 0 when their enable is low.
- Source equal to destination (e.g. ADD R3,R3,R3) is legal: reads are held through WR_S and the write lands at the WR_S→IDLE edge.
- Reset mid-instruction: immediate return to IDLE with all controls 0. No partial write occurs unless the WE edge has already passed.

Optional Feature:
- Macro DATAPATH_CTRL_PERF_CNT_EN.
- Defined: instr_count increments by 1 on every cycle where done = 1, wrapping from 2^CNT_WIDTH-1 to 0. It resets to 0 asynchronously.
- Undefined: the instr_count port is driven constant 0 and no counter flops are built.

Test Plan:
- Reset: hold RST_N low 3 cycles, release -> instr_ready = 1, busy = 0, all controls 0; assert RST_N low mid-cycle -> controls clear before the next edge.
- LOAD R5, Inport = 0x3C (instr 0x340) -> next cycle IE = 1, WE = 1, WA = 5, done = 1; then IDLE.
  - With the datapath attached, a following OUT R5 (0xE28) shows OE = 1, RAA = 5, Outport = 0x3C.
- SUB R2,R5,R1 (instr 0x6A9) -> cycle 1: REA = REB = 1, RAA = 5, RAB = 1, alu_op = 01, WE = 0; cycle 2: additionally WE = 1, WA = 2, done = 1.
- Back-to-back: instr_valid held high with ADD then ADDSH (0xC49) -> the second is accepted only after an IDLE cycle; ADDSH shows shift_en = 1 in both RD_S and WR_S.
- Reset asserted during RD_S of an ADD -> WE never asserts, done never pulses, instr_ready = 1 after release.
- With DATAPATH_CTRL_PERF_CNT_EN and CNT_WIDTH = 4: issue 17 instructions -> instr_count = 1 (wrap); without the macro, instr_count stays 0.
